game_ctrl_fsm: RTL and testbench

- Parametrised successor to the single-player game state machine: multi-player scoring, internal countdown timer, pause/resume, automatic return to idle, and a persistent high score.
- Sits between the debounced button/sensor inputs and the seven-segment/LED display logic.
- All logic runs on the 100 MHz `clkIn`. The 1 Hz timebase arrives as a one-cycle enable pulse synchronous to `clkIn`, not as a separate clock.

---
 rtl/game_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm.sv
// Game controller: multi-player scoring, 1 Hz countdown, pause/resume, timed finish
// hold with auto-return to idle, and a high score that persists across games.
module game_ctrl_fsm #(
  parameter int GAME_SECONDS   = 30,
  parameter int FINISH_SECONDS = 5,
  parameter int NUM_PLAYERS    = 2,
  parameter int SCORE_W        = 6
) (
  input  logic                           clkIn,
  input  logic                           reset,
  input  logic                           tick_1hz,
  input  logic                           startGame,
  input  logic                           pauseGame,
  input  logic [NUM_PLAYERS-1:0]         player_scored,
  output logic [1:0]                     state,
  output logic                           game_active,
  output logic                           game_over,
  output logic [7:0]                     time_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [SCORE_W-1:0]             high_score,
  output logic [2:0]                     winner,
  output logic                           tie
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_PAUSED  = 2'b10,
    S_FINISH  = 2'b11
  } state_t;

  localparam logic [7:0]         GAME_T    = 8'(GAME_SECONDS);
  localparam logic [7:0]         FINISH_T  = 8'(FINISH_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q, state_d;
  logic [7:0]         time_q, time_d;
  logic [7:0]         fin_q, fin_d;
  logic [SCORE_W-1:0] score_q   [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_d   [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_inc [NUM_PLAYERS];
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic [2:0]         win_q, win_d;
  logic               tie_q, tie_d;
  logic               active_q, active_d;
  logic               over_q, over_d;

  logic [SCORE_W-1:0] top_score;
  logic [2:0]         top_idx;
  logic [3:0]         top_cnt;

  // Scores with this cycle's pulses applied, saturating at the maximum.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_inc[i] = score_q[i];
      if (player_scored[i] && score_q[i] != SCORE_MAX)
        score_inc[i] = score_q[i] + 1'b1;
    end
  end

  // Strict '>' keeps the lowest index among equal top scorers.
  always_comb begin
    top_score = '0;
    top_idx   = '0;
    top_cnt   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (score_inc[i] > top_score) begin
        top_score = score_inc[i];
        top_idx   = 3'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (score_inc[i] == top_score) top_cnt = top_cnt + 4'd1;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    time_d  = time_q;
    fin_d   = fin_q;
    score_d = score_q;
    hs_d    = hs_q;
    win_d   = win_q;
    tie_d   = tie_q;

    case (state_q)
      S_IDLE: begin
        if (startGame) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (!startGame) begin
          score_d = score_inc;
          if (tick_1hz && time_q <= 8'd1) begin
            time_d  = '0;
            state_d = S_FINISH;
            fin_d   = '0;
            win_d   = top_idx;
            tie_d   = (top_cnt > 4'd1);
            if (top_score > hs_q) hs_d = top_score;
          end else begin
            if (tick_1hz)  time_d  = time_q - 8'd1;
            if (pauseGame) state_d = S_PAUSED;
          end
        end
      end
      S_PAUSED: begin
        if (!startGame && pauseGame) state_d = S_RUNNING;
      end
      S_FINISH: begin
        if (!startGame && tick_1hz) begin
          fin_d = fin_q + 8'd1;
          if (fin_d == FINISH_T) begin
            state_d = S_IDLE;
            time_d  = GAME_T;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = GAME_T;
      end
    endcase

    // startGame opens a fresh game from any state and overrides pause/auto-return.
    if (startGame) begin
      state_d = S_RUNNING;
      time_d  = GAME_T;
      score_d = '{default: '0};
    end

    active_d = (state_d == S_RUNNING) || (state_d == S_PAUSED);
    over_d   = (state_d == S_FINISH);
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      time_q   <= GAME_T;
      fin_q    <= '0;
      // NOTE: the score array is small and visible on outputs, so it is reset like any flop.
      score_q  <= '{default: '0};
      hs_q     <= '0;
      win_q    <= '0;
      tie_q    <= 1'b0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      time_q   <= time_d;
      fin_q    <= fin_d;
      score_q  <= score_d;
      hs_q     <= hs_d;
      win_q    <= win_d;
      tie_q    <= tie_d;
      active_q <= active_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      score[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  assign state       = state_q;
  assign game_active = active_q;
  assign game_over   = over_q;
  assign time_left   = time_q;
  assign high_score  = hs_q;
  assign winner      = win_q;
  assign tie         = tie_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: directed scenarios plus random traffic,
// compared every cycle against a behavioural game model.
module tb_game_ctrl_fsm;

  localparam int GS = 30;
  localparam int FS = 5;
  localparam int NP = 2;
  localparam int SW = 6;
  localparam int SMAX = (1 << SW) - 1;

  logic             clkIn = 1'b0;
  logic             reset;
  logic             tick_1hz, startGame, pauseGame;
  logic [NP-1:0]    player_scored;
  logic [1:0]       state;
  logic             game_active, game_over;
  logic [7:0]       time_left;
  logic [NP*SW-1:0] score;
  logic [SW-1:0]    high_score;
  logic [2:0]       winner;
  logic             tie;

  int n_checks = 0;
  int n_pass   = 0;

  game_ctrl_fsm #(
    .GAME_SECONDS(GS), .FINISH_SECONDS(FS), .NUM_PLAYERS(NP), .SCORE_W(SW)
  ) dut (
    .clkIn(clkIn), .reset(reset), .tick_1hz(tick_1hz), .startGame(startGame),
    .pauseGame(pauseGame), .player_scored(player_scored), .state(state),
    .game_active(game_active), .game_over(game_over), .time_left(time_left),
    .score(score), .high_score(high_score), .winner(winner), .tie(tie)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: the game as described in words, with plain integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FIN = 3;
  int m_mode, m_time, m_fin, m_hs, m_win, m_tie;
  int m_sc[NP];

  task automatic m_new_game();
    m_mode = M_RUN;
    m_time = GS;
    foreach (m_sc[i]) m_sc[i] = 0;
  endtask

  task automatic m_settle_results();
    int best, holders;
    best = 0;
    foreach (m_sc[i]) if (m_sc[i] > best) best = m_sc[i];
    holders = 0;
    m_win = -1;
    foreach (m_sc[i]) if (m_sc[i] == best) begin
      holders++;
      if (m_win < 0) m_win = i;
    end
    m_tie = (holders > 1);
    if (best > m_hs) m_hs = best;
  endtask

  always @(posedge clkIn or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_time = GS; m_fin = 0;
      m_hs = 0; m_win = 0; m_tie = 0;
      foreach (m_sc[i]) m_sc[i] = 0;
    end else if (startGame) begin
      m_new_game();
    end else if (m_mode == M_RUN) begin
      foreach (m_sc[i]) if (player_scored[i] && m_sc[i] < SMAX) m_sc[i]++;
      if (tick_1hz && m_time == 1) begin
        m_time = 0; m_mode = M_FIN; m_fin = 0;
        m_settle_results();
      end else begin
        if (tick_1hz) m_time--;
        if (pauseGame) m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE) begin
      if (pauseGame) m_mode = M_RUN;
    end else if (m_mode == M_FIN && tick_1hz) begin
      m_fin++;
      if (m_fin == FS) begin m_mode = M_IDLE; m_time = GS; end
    end
  end

  // Per-cycle comparison against the model, clear of the rising edge.
  always @(negedge clkIn) begin
    if (!reset) begin
      check("state", state, m_mode);
      check("game_active", game_active, (m_mode == M_RUN || m_mode == M_PAUSE));
      check("game_over", game_over, (m_mode == M_FIN));
      check("time_left", time_left, m_time);
      for (int i = 0; i < NP; i++) check($sformatf("score%0d", i), score[i*SW +: SW], m_sc[i]);
      check("high_score", high_score, m_hs);
      check("winner", winner, m_win);
      check("tie", tie, m_tie);
    end
  end

  // One clock of stimulus: inputs set at a falling edge, cleared at the next.
  task automatic cyc(input bit t, input bit s, input bit p, input logic [NP-1:0] ps);
    tick_1hz = t; startGame = s; pauseGame = p; player_scored = ps;
    @(negedge clkIn);
    tick_1hz = 1'b0; startGame = 1'b0; pauseGame = 1'b0; player_scored = '0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; startGame = 1'b0; pauseGame = 1'b0; player_scored = '0;
    #1;
    check("rst_state", state, 0);
    check("rst_time", time_left, GS);
    check("rst_score", score, 0);
    check("rst_over", game_over, 0);
    @(negedge clkIn); @(negedge clkIn);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 2'b11);   // all ignored in IDLE
    check("idle_ignore_time", time_left, GS);

    // Full countdown and auto-return.
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("start_time", time_left, 30);
    for (int k = 1; k <= GS; k++) begin
      cyc(1'b1, 1'b0, 1'b0, '0);
      if (k < GS) check("countdown", time_left, 30 - k);
    end
    check("expire_state", state, 2'b11);
    check("expire_time", time_left, 0);
    check("expire_over", game_over, 1);
    ticks(FS - 1);
    check("finish_hold", state, 2'b11);
    ticks(1);
    check("auto_idle_state", state, 2'b00);
    check("auto_idle_time", time_left, 30);

    // Scoring with a simultaneous double pulse.
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, 2'b11);
    cyc(1'b0, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 1'b0, 1'b0, 2'b01);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 2'b10);
    check("score_53", score, {6'd5, 6'd3});
    ticks(GS);
    check("win_p1", winner, 1);
    check("win_tie0", tie, 0);
    check("hs_5", high_score, 5);

    // startGame in FINISH, then saturation.
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("restart_state", state, 2'b01);
    check("restart_time", time_left, 30);
    check("restart_score", score, 0);
    check("restart_hs", high_score, 5);
    for (int k = 0; k < 70; k++) cyc(1'b0, 1'b0, 1'b0, 2'b01);
    check("saturate", score[SW-1:0], 63);

    // Pause freezes time and scores.
    cyc(1'b0, 1'b1, 1'b0, '0);
    ticks(10);
    check("pre_pause_time", time_left, 20);
    cyc(1'b0, 1'b0, 1'b1, '0);
    check("paused_state", state, 2'b10);
    cyc(1'b1, 1'b0, 1'b0, 2'b11);
    cyc(1'b1, 1'b0, 1'b0, 2'b01);
    ticks(2);
    cyc(1'b0, 1'b0, 1'b1, '0);
    check("resume_state", state, 2'b01);
    check("resume_time", time_left, 20);
    check("resume_score", score, 0);
    ticks(1);
    check("resume_tick", time_left, 19);

    // Score on the expiring tick: clear winner, then a tie.
    cyc(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b0, 2'b11);
    ticks(GS - 1);
    cyc(1'b1, 1'b0, 1'b0, 2'b01);
    check("last_tick_score0", score[SW-1:0], 3);
    check("last_tick_win", winner, 0);
    check("last_tick_tie", tie, 0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b0, 2'b11);
    cyc(1'b0, 1'b0, 1'b0, 2'b01);
    ticks(GS - 1);
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    check("tie_score", score, {6'd3, 6'd3});
    check("tie_win", winner, 0);
    check("tie_flag", tie, 1);
    check("tie_hs", high_score, 5);

    // Asynchronous mid-game reset, no clock edge in between.
    cyc(1'b0, 1'b1, 1'b0, '0);
    ticks(3);
    cyc(1'b0, 1'b0, 1'b0, 2'b01);
    #2 reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_active", game_active, 0);
    check("arst_time", time_left, GS);
    check("arst_score", score, 0);
    check("arst_hs", high_score, 0);
    check("arst_tie", tie, 0);
    @(negedge clkIn);
    reset = 1'b0;

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 120) == 0),
          ($urandom_range(0, 15) == 0), NP'($urandom_range(0, 3) & $urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
